// File: rtl/linebuf_pkg.sv
// Shared defaults and types for the streaming window line buffer.
// The window layout is row-major: element i*WIN+j is row i, column j,
// with element 0 the top-left pixel of the neighbourhood.
package linebuf_pkg;

  localparam int DEF_PW    = 7;
  localparam int DEF_WIN   = 9;
  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;

  localparam int DEF_WIN_ELEMS = DEF_WIN * DEF_WIN;

  typedef logic [DEF_PW-1:0] pix_t;
  typedef pix_t window_t [0:DEF_WIN_ELEMS-1];

  // Flat index of window row i, column j.
  function automatic int win_idx(input int i, input int j, input int win);
    return i * win + j;
  endfunction

endpackage

// File: rtl/row_delay.sv
// One image-row delay line: a DEPTH-deep shift register that advances only
// when enabled. The output is the sample accepted DEPTH enables earlier,
// i.e. the pixel directly above the one currently entering.
module row_delay
  import linebuf_pkg::*;
#(
  parameter int PW    = DEF_PW,
  parameter int DEPTH = DEF_IMG_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [PW-1:0] i_d,
  output logic [PW-1:0] o_q
);

  logic [PW-1:0] r_mem [0:DEPTH-1];

  // Shift one position per accepted pixel; hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else if (i_en) begin
      r_mem[0] <= i_d;
      for (int k = 1; k < DEPTH; k++) begin
        r_mem[k] <= r_mem[k-1];
      end
    end
  end

  assign o_q = r_mem[DEPTH-1];

endmodule

// File: rtl/window_linebuffer.sv
// Streaming WIN x WIN window generator. Raster pixels enter one per accepted
// cycle; WIN-1 chained row delay lines provide the pixels above the incoming
// one, and a WIN x WIN register array shifts left one column per pixel.
// Interface: pix_valid is a one-way strobe with no backpressure. A pixel is
// consumed on every posedge where pix_valid=1; all outputs update on the
// following cycle, and win_valid/frame_done are one-cycle pulses that the
// consumer must sample in that cycle.
module window_linebuffer
  import linebuf_pkg::*;
#(
  parameter int PW    = DEF_PW,
  parameter int WIN   = DEF_WIN,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PW-1:0]            pix_in,
  input  logic                     pix_valid,
  input  logic                     sof,
  output logic [PW-1:0]            xarray [0:WIN*WIN-1],
  output logic                     win_valid,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     frame_done
);

  localparam int RW    = $clog2(IMG_H);
  localparam int CW    = $clog2(IMG_W);
  localparam int NLINE = WIN - 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_WIN0 = RW'(WIN - 1);
  localparam logic [CW-1:0] COL_WIN0 = CW'(WIN - 1);

  // Position of the next pixel to be accepted.
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;

  // Window registers, row-major, element 0 = top-left.
  logic [PW-1:0] r_win [0:WIN*WIN-1];

  // Coordinates of the pixel on the input this cycle; sof forces (0,0).
  logic [RW-1:0] w_cur_row;
  logic [CW-1:0] w_cur_col;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_in_window;

  // Delay-line chain: w_line_in[k] feeds line k, w_tap[k] is its output.
  // Line k's output is the pixel k+1 rows above the incoming one.
  logic [PW-1:0] w_line_in [0:NLINE-1];
  logic [PW-1:0] w_tap     [0:NLINE-1];

  // New right-hand window column, oldest row at the top.
  logic [PW-1:0] w_new_col [0:WIN-1];

  assign w_cur_row   = sof ? '0 : r_row;
  assign w_cur_col   = sof ? '0 : r_col;
  assign w_col_last  = (w_cur_col == COL_LAST);
  assign w_row_last  = (w_cur_row == ROW_LAST);
  // Windows straddling a row wrap or the top of the frame are not flagged.
  assign w_in_window = (w_cur_row >= ROW_WIN0) && (w_cur_col >= COL_WIN0);

  genvar g;
  generate
    for (g = 0; g < NLINE; g++) begin : g_lines
      if (g == 0) begin : g_head
        assign w_line_in[g] = pix_in;
      end else begin : g_chain
        assign w_line_in[g] = w_tap[g-1];
      end

      row_delay #(
        .PW    (PW),
        .DEPTH (IMG_W)
      ) u_row_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (pix_valid),
        .i_d   (w_line_in[g]),
        .o_q   (w_tap[g])
      );

      assign w_new_col[g] = w_tap[NLINE-1-g];
    end
  endgenerate

  assign w_new_col[WIN-1] = pix_in;

  // Raster position counters; sof restarts the frame at the current pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (pix_valid) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : w_cur_row + RW'(1);
      end else begin
        r_col <= w_cur_col + CW'(1);
        r_row <= w_cur_row;
      end
    end
  end

  // Window array: shift left one column and load the new right column.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < WIN*WIN; k++) begin
        r_win[k] <= '0;
      end
    end else if (pix_valid) begin
      for (int i = 0; i < WIN; i++) begin
        for (int j = 0; j < WIN - 1; j++) begin
          r_win[win_idx(i, j, WIN)] <= r_win[win_idx(i, j + 1, WIN)];
        end
        r_win[win_idx(i, WIN - 1, WIN)] <= w_new_col[i];
      end
    end
  end

  // Output flags and coordinates; pulses drop on any cycle without a pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
    end else begin
      win_valid  <= pix_valid && w_in_window;
      frame_done <= pix_valid && w_col_last && w_row_last;
      if (pix_valid) begin
        win_row <= w_cur_row;
        win_col <= w_cur_col;
      end
    end
  end

  assign xarray = r_win;

endmodule

// File: doc/window_linebuffer.md
# window_linebuffer

Streaming 9x9 window generator that feeds the per-class inner-product units of the line-buffered logistic-regression classifier. It accepts a raster-order pixel stream, stores the last WIN-1 image rows, and presents each complete WIN x WIN neighbourhood as an 81-element array of 7-bit pixels. The array uses the same index layout as the inner-product units' `xarray` input. This block is the producer side of that array interface; all inner-product units are combinational consumers in parallel.

## Interface
Parameters:
- PW, 7: pixel width in bits
- WIN, 9: window edge; the window holds WIN*WIN = 81 elements
- IMG_W, 28: image width in pixels
- IMG_H, 28: image height in pixels

Ports:
- clk  in  1  sole clock; all logic rises on posedge
- rst_n  in  1  synchronous, active-low reset
- pix_in  in  PW  pixel value
- pix_valid  in  1  pix_in is accepted this cycle (no backpressure)
- sof  in  1  start of frame; only meaningful while pix_valid=1
- xarray  out  PW x [0:WIN*WIN-1]  window, unpacked array
- win_valid  out  1  xarray holds a complete in-frame window (one-cycle pulse)
- win_row, win_col  out  $clog2(IMG_H), $clog2(IMG_W)  bottom-right pixel coordinates of the presented window
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) give the position of the next accepted pixel.
- Counters advance only when pix_valid=1:
  - col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1) both wrap to 0 and frame_done pulses.
- If pix_valid=1 and sof=1, the pixel is taken as (0,0) regardless of the counters. sof with pix_valid=0 is ignored.
- Line storage: WIN-1 row delay lines of IMG_W entries, chained. Each accepted pixel shifts every delay line by one. pix_valid=0 freezes all storage.
- Window register: WIN x WIN registers that shift left by one column per accepted pixel. The new right column is loaded from the delay-line taps (oldest row at the top) plus pix_in at the bottom.
- Mapping: xarray[i*WIN+j] = pixel(r-(WIN-1)+i, c-(WIN-1)+j), where (r,c) is the bottom-right pixel. Element 0 carries the top-left pixel. Consumers that use slot 0 as the bias term ignore it.
- win_valid=1 only when the accepted pixel satisfies r>=WIN-1 and c>=WIN-1. Windows that straddle a row wrap are never flagged.
- Each frame therefore produces (IMG_H-WIN+1)*(IMG_W-WIN+1) windows; the defaults give 400.
- sof does not clear storage. Stale data only ever occupies unflagged windows.
- Reset values: all counters 0, window registers 0, delay lines 0, win_valid=0, frame_done=0, win_row=0, win_col=0, xarray all 0.

## Timing
- Latency is 1 cycle: a pixel accepted at cycle t updates xarray, win_valid, win_row, win_col and frame_done at t+1.
- win_valid and frame_done are single-cycle pulses. They are 0 on any cycle that follows a cycle with pix_valid=0.
- xarray holds its value between accepted pixels.
- On back-to-back valid pixels a new window can appear every cycle. The consumer must sample in the same cycle.
- Reset mid-frame clears everything in the next cycle. The next accepted pixel is (0,0) with or without sof.
- sof mid-frame restarts counting at that pixel, which is (0,0). No frame_done is issued for the aborted frame.

## Structure
- Shared package `linebuf_pkg`:
  - default PW, WIN, IMG_W, IMG_H
  - typedef `pix_t` (logic [PW-1:0])
  - typedef `window_t` (pix_t array of WIN*WIN)
- Sub-module `row_delay`: an IMG_W-deep shift register with an enable, instantiated WIN-1 times.
- Counters, window registers and the output flags live in the top module.

## Test plan
- Continuous 28x28 frame with pixel = (r*28+c) mod 128:
  - First win_valid appears 1 cycle after pixel index 232.
  - In that window, xarray[0]=0, xarray[8]=8, xarray[80]=104, win_row=8, win_col=8.
  - Exactly 400 win_valid pulses and one frame_done follow.
- Same frame with pix_valid deasserted on random cycles (about 30%): window contents and count are identical, xarray holds during gaps, and no pulse occurs during gaps.
- Two back-to-back frames, the second starting with sof: second-frame windows match the first-frame reference exactly, 400 pulses each, and frame_done occurs twice.
- sof asserted at pixel 500 of a frame: the next first win_valid occurs after 232 further pixels and carries new-frame data. No frame_done is issued for the aborted frame.
- rst_n low for one cycle mid-frame: all outputs read 0 the next cycle. A following stream with no sof behaves exactly as the first test.
- Row-wrap check: no win_valid for c<8 on any row, for example no pulse after pixels (9,0) through (9,7).
